backprop_sequencer: RTL and testbench
=====================================

BACKPROP_SEQUENCER -- requirements
Module: backprop_sequencer

Interface
REQ-001 SHALL have parameter max_layer_size, default 4, maximum number of layers sequenced.
REQ-002 SHALL have parameter size, default 3, rows per layer.
REQ-003 SHALL have parameter backprop_controll_size, default 66, bundle width (1+1+32+32).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request to begin one store-then-train pass.
REQ-007 SHALL have port num_layers, input, 32 bits: layer count, sampled only on an accepted start.
REQ-008 SHALL have port store_valid, input, 1 bit: the forward datapath presents one activation row this cycle.
REQ-009 SHALL have port layer_ack, input, 1 bit: the stack controller has finished the current layer (its start_new_layer).
REQ-010 SHALL have port backprop_controll_bundle, output, backprop_controll_size bits: {is_store[65], start_train[64], current_input_layer[63:32], current_input_row[31:0]}.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at pass completion.
REQ-013 SHALL have port err, output, 1 bit: sticky error flag, cleared by the next accepted start or by rst.

Function
REQ-014 SHALL drive every output from a register; each response appears one clock after the causing input.
REQ-015 SHALL implement the states IDLE, STORE, TRAIN_START, TRAIN, WAIT_LAYER and DONE.
REQ-016 IDLE: bundle all zero. start with 1<=num_layers<=max_layer_size -> STORE, with layer=0, row=0, err cleared.
REQ-017 IDLE: start with num_layers==0 or num_layers>max_layer_size -> err=1, stay in IDLE, no done.
REQ-018 STORE: on a cycle with store_valid=1, the next bundle SHALL be is_store=1, start_train=0, current layer and row; row then increments.
REQ-019 STORE: on a cycle with store_valid=0, the bundle SHALL return to all zero and the counters SHALL hold.
REQ-020 STORE: row wraps from size-1 to 0 and layer increments; after row size-1 of layer num_layers-1 -> TRAIN_START.
REQ-021 TRAIN_START: for exactly one cycle the bundle SHALL be is_store=0, start_train=1, layer=num_layers-1, row=0; then -> TRAIN.
REQ-022 TRAIN: one row per cycle with no stall, bundle is_store=0, start_train=0, rows 0..size-1 of the current layer; after row size-1 -> WAIT_LAYER.
REQ-023 WAIT_LAYER: bundle flags SHALL be 0 with layer/row held until layer_ack=1.
REQ-024 On layer_ack in WAIT_LAYER: if layer==0 -> DONE; otherwise layer decrements, row=0 -> TRAIN.
REQ-025 DONE: done=1 for one cycle, bundle zero, then -> IDLE; busy=0 starting the cycle after DONE.
REQ-026 SHALL ignore start while busy=1, and SHALL ignore layer_ack outside WAIT_LAYER.
REQ-027 SHALL ignore store_valid outside STORE.
REQ-028 Layer and row counters SHALL be 32 bits, zero-extended into the bundle fields.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, bundle=0, busy=0, done=0, err=0, counters=0, from any state including mid-pass.
REQ-030 rst SHALL take priority over start and every other input in the same cycle.

Configuration
REQ-031 Macro BACKPROP_SEQ_TIMEOUT_EN defined: an 8-bit watchdog counts cycles in WAIT_LAYER; after 256 cycles without layer_ack -> err=1, return to IDLE with bundle=0 and no done pulse.
REQ-032 Macro BACKPROP_SEQ_TIMEOUT_EN undefined: no watchdog; WAIT_LAYER waits indefinitely; err is set only by REQ-017.

Verification
REQ-033 num_layers=2, size=3, store_valid held high -> six is_store bundles (L0 R0-2, L1 R0-2), then bundle with start_train=1, layer=1, row=0, then L1 R0-2.
REQ-034 Continue REQ-033, layer_ack pulsed 2 cycles after entering WAIT_LAYER -> L0 R0-2, WAIT_LAYER, ack -> done pulses once, busy falls the next cycle.
REQ-035 start with num_layers=0, and separately num_layers=5 -> err=1, busy stays 0, bundle stays 0; a later valid start clears err.
REQ-036 store_valid toggling 1,0,1 in STORE -> bundles L0R0, zero, L0R1; a second start during TRAIN is ignored.
REQ-037 rst asserted in TRAIN at L1 R1 -> next cycle all outputs zero, IDLE; a fresh start restarts from L0 R0.
REQ-038 With BACKPROP_SEQ_TIMEOUT_EN defined and no layer_ack -> err=1 and IDLE exactly 256 cycles after entering WAIT_LAYER, done never asserted.

Source files
------------

// File: rtl/backprop_sequencer.sv
// Store-then-train sequencer: emits one control bundle per cycle, all outputs registered.
// Optional WAIT_LAYER watchdog enabled by defining BACKPROP_SEQ_TIMEOUT_EN.
module backprop_sequencer #(
   parameter int max_layer_size         = 4,
   parameter int size                   = 3,
   parameter int backprop_controll_size = 66
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [31:0]                       num_layers,
   input  logic                              store_valid,
   input  logic                              layer_ack,
   output logic [backprop_controll_size-1:0] backprop_controll_bundle,
   output logic                              busy,
   output logic                              done,
   output logic                              err
);

   // Handshake: start is accepted only in IDLE; store_valid only in STORE;
   // layer_ack only in WAIT_LAYER. All other cycles these inputs are ignored.

   typedef enum logic [2:0] {
      IDLE, STORE, TRAIN_START, TRAIN, WAIT_LAYER, DONE
   } state_t;

   localparam logic [31:0] last_row  = 32'(size - 1);
   localparam logic [31:0] max_layer = 32'(max_layer_size);

   state_t      state_q, state_d;
   logic [31:0] layer_q, layer_d;
   logic [31:0] row_q, row_d;
   logic [31:0] nl_q, nl_d;
   logic [backprop_controll_size-1:0] bundle_q, bundle_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
`ifdef BACKPROP_SEQ_TIMEOUT_EN
   logic [7:0]  wd_q, wd_d;
`endif

   function automatic logic [backprop_controll_size-1:0] mk(input logic is_store,
                                                            input logic start_train,
                                                            input logic [31:0] layer,
                                                            input logic [31:0] row);
      logic [65:0] b;
      b = {is_store, start_train, layer, row};
      return backprop_controll_size'(b);
   endfunction

   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      row_d    = row_q;
      nl_d     = nl_q;
      bundle_d = bundle_q;
      done_d   = 1'b0;
      err_d    = err_q;
`ifdef BACKPROP_SEQ_TIMEOUT_EN
      wd_d     = wd_q;
`endif
      case (state_q)
         IDLE: begin
            bundle_d = '0;
            if (start) begin
               if (num_layers != 32'd0 && num_layers <= max_layer) begin
                  state_d = STORE;
                  layer_d = 32'd0;
                  row_d   = 32'd0;
                  nl_d    = num_layers;
                  err_d   = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         STORE: begin
            if (store_valid) begin
               bundle_d = mk(1'b1, 1'b0, layer_q, row_q);
               if (row_q == last_row) begin
                  row_d = 32'd0;
                  if (layer_q == nl_q - 32'd1) state_d = TRAIN_START;
                  else                         layer_d = layer_q + 32'd1;
               end else begin
                  row_d = row_q + 32'd1;
               end
            end else begin
               bundle_d = '0;
            end
         end
         TRAIN_START: begin
            bundle_d = mk(1'b0, 1'b1, nl_q - 32'd1, 32'd0);
            layer_d  = nl_q - 32'd1;
            row_d    = 32'd0;
            state_d  = TRAIN;
         end
         TRAIN: begin
            bundle_d = mk(1'b0, 1'b0, layer_q, row_q);
            if (row_q == last_row) begin
               state_d = WAIT_LAYER;
`ifdef BACKPROP_SEQ_TIMEOUT_EN
               wd_d    = 8'd0;
`endif
            end else begin
               row_d = row_q + 32'd1;
            end
         end
         WAIT_LAYER: begin
            // Row counter stays at the last trained row, so the bundle holds.
            bundle_d = mk(1'b0, 1'b0, layer_q, row_q);
            if (layer_ack) begin
               if (layer_q == 32'd0) begin
                  state_d  = DONE;
                  done_d   = 1'b1;
                  bundle_d = '0;
               end else begin
                  layer_d = layer_q - 32'd1;
                  row_d   = 32'd0;
                  state_d = TRAIN;
               end
            end
`ifdef BACKPROP_SEQ_TIMEOUT_EN
            else if (wd_q == 8'hff) begin
               state_d  = IDLE;
               err_d    = 1'b1;
               bundle_d = '0;
            end else begin
               wd_d = wd_q + 8'd1;
            end
`endif
         end
         DONE: begin
            bundle_d = '0;
            state_d  = IDLE;
         end
         default: begin
            bundle_d = '0;
            state_d  = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         layer_q  <= '0;
         row_q    <= '0;
         nl_q     <= '0;
         bundle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef BACKPROP_SEQ_TIMEOUT_EN
         wd_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         row_q    <= row_d;
         nl_q     <= nl_d;
         bundle_q <= bundle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef BACKPROP_SEQ_TIMEOUT_EN
         wd_q     <= wd_d;
`endif
      end
   end

   assign backprop_controll_bundle = bundle_q;
   assign busy                     = busy_q;
   assign done                     = done_q;
   assign err                      = err_q;

endmodule

// File: tb/tb_backprop_sequencer.sv
// Directed bench for backprop_sequencer: store/train pass, error starts, store gaps,
// mid-pass reset and WAIT_LAYER behaviour (watchdog or indefinite wait).
module tb_backprop_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] num_layers;
   logic        store_valid;
   logic        layer_ack;
   logic [65:0] bundle;
   logic        busy, done, err;

   int tests = 0;
   int fails = 0;
   logic [65:0] exp_q[$];
   logic        saw_done;

   backprop_sequencer #(.max_layer_size(4), .size(3), .backprop_controll_size(66)) dut (
      .clk(clk), .rst(rst), .start(start), .num_layers(num_layers),
      .store_valid(store_valid), .layer_ack(layer_ack),
      .backprop_controll_bundle(bundle), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [65:0] bnd(input logic s, input logic t, input int l, input int r);
      return {s, t, 32'(l), 32'(r)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic b, input logic d, input logic e);
      chk({tag, "_busy"}, 66'(busy), 66'(b));
      chk({tag, "_done"}, 66'(done), 66'(d));
      chk({tag, "_err"},  66'(err),  66'(e));
   endtask

   task automatic drain(input string tag);
      logic [65:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         chk(tag, bundle, e);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_layers = 32'd0; store_valid = 1'b0; layer_ack = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_bundle", bundle, '0);
      chk_flags("reset", 1'b0, 1'b0, 1'b0);

      // Full pass, two layers, store_valid held high
      start = 1'b1; num_layers = 32'd2; store_valid = 1'b1;
      tick();
      start = 1'b0;
      chk("pass_start_bundle", bundle, '0);
      chk_flags("pass_start", 1'b1, 1'b0, 1'b0);
      for (int l = 0; l < 2; l++)
         for (int r = 0; r < 3; r++) exp_q.push_back(bnd(1, 0, l, r));
      exp_q.push_back(bnd(0, 1, 1, 0));
      for (int r = 0; r < 3; r++) exp_q.push_back(bnd(0, 0, 1, r));
      drain("pass_l1");
      store_valid = 1'b0;
      tick(); chk("wait1_hold", bundle, bnd(0, 0, 1, 2));
      tick(); chk("wait1_hold2", bundle, bnd(0, 0, 1, 2));
      chk_flags("wait1", 1'b1, 1'b0, 1'b0);
      layer_ack = 1'b1;
      tick();
      layer_ack = 1'b0;
      chk("ack1_bundle", bundle, bnd(0, 0, 1, 2));
      for (int r = 0; r < 3; r++) exp_q.push_back(bnd(0, 0, 0, r));
      drain("pass_l0");
      tick(); chk("wait0_hold", bundle, bnd(0, 0, 0, 2));
      layer_ack = 1'b1;
      tick();
      layer_ack = 1'b0;
      chk("done_bundle", bundle, '0);
      chk_flags("done", 1'b1, 1'b1, 1'b0);
      tick();
      chk_flags("after_done", 1'b0, 1'b0, 1'b0);

      // Invalid layer counts
      start = 1'b1; num_layers = 32'd0;
      tick();
      start = 1'b0;
      chk("zero_bundle", bundle, '0);
      chk_flags("zero_layers", 1'b0, 1'b0, 1'b1);
      tick();
      chk("err_sticky", 66'(err), 66'(1'b1));
      start = 1'b1; num_layers = 32'd5;
      tick();
      start = 1'b0;
      chk("five_bundle", bundle, '0);
      chk_flags("five_layers", 1'b0, 1'b0, 1'b1);

      // Valid start clears err; store gaps; ack during STORE and start during TRAIN ignored
      start = 1'b1; num_layers = 32'd1; layer_ack = 1'b1;
      tick();
      start = 1'b0;
      chk_flags("clear_err", 1'b1, 1'b0, 1'b0);
      store_valid = 1'b1; tick(); chk("gap_r0", bundle, bnd(1, 0, 0, 0));
      store_valid = 1'b0; tick(); chk("gap_zero", bundle, '0);
      store_valid = 1'b1; tick(); chk("gap_r1", bundle, bnd(1, 0, 0, 1));
      tick(); chk("gap_r2", bundle, bnd(1, 0, 0, 2));
      store_valid = 1'b0; layer_ack = 1'b0;
      tick(); chk("gap_ts", bundle, bnd(0, 1, 0, 0));
      start = 1'b1; num_layers = 32'd0; store_valid = 1'b1;
      tick(); chk("ign_r0", bundle, bnd(0, 0, 0, 0));
      tick(); chk("ign_r1", bundle, bnd(0, 0, 0, 1));
      start = 1'b0; store_valid = 1'b0;
      tick(); chk("ign_r2", bundle, bnd(0, 0, 0, 2));
      chk_flags("ign_start", 1'b1, 1'b0, 1'b0);
      layer_ack = 1'b1;
      tick();
      layer_ack = 1'b0;
      chk_flags("gap_done", 1'b1, 1'b1, 1'b0);
      tick();
      chk_flags("gap_idle", 1'b0, 1'b0, 1'b0);

      // Reset mid-pass at L1 R1
      start = 1'b1; num_layers = 32'd2; store_valid = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("pre_rst", bundle, bnd(0, 0, 1, 1));
      rst = 1'b1; start = 1'b1;
      tick();
      chk("rst_bundle", bundle, '0);
      chk_flags("rst_mid", 1'b0, 1'b0, 1'b0);
      tick();
      chk("rst_prio_busy", 66'(busy), 66'(1'b0));
      rst = 1'b0;
      tick();
      start = 1'b0;
      for (int l = 0; l < 2; l++)
         for (int r = 0; r < 3; r++) exp_q.push_back(bnd(1, 0, l, r));
      exp_q.push_back(bnd(0, 1, 1, 0));
      for (int r = 0; r < 3; r++) exp_q.push_back(bnd(0, 0, 1, r));
      drain("restart");
      store_valid = 1'b0;

      // WAIT_LAYER without ack
      saw_done = 1'b0;
      for (int i = 0; i < 255; i++) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      chk_flags("wd_255", 1'b1, 1'b0, 1'b0);
      tick();
      if (done) saw_done = 1'b1;
`ifdef BACKPROP_SEQ_TIMEOUT_EN
      chk("wd_bundle", bundle, '0);
      chk_flags("wd_256", 1'b0, 1'b0, 1'b1);
`else
      for (int i = 0; i < 50; i++) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      chk("nowd_bundle", bundle, bnd(0, 0, 1, 2));
      chk_flags("nowd_wait", 1'b1, 1'b0, 1'b0);
`endif
      chk("wd_no_done", 66'(saw_done), 66'(1'b0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
